// File: rtl/bomb_pkg.sv
// Shared types and default parameters for the
// button front-end of the bomb project.
package bomb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_HOLD   = 2'd1,
    ST_REPEAT = 2'd2
  } btn_state_e;

  localparam int DEF_NUM_BTN        = 5;
  localparam int DEF_STABLE_SAMPLES = 4;
  localparam int DEF_REPEAT_DELAY   = 32;
  localparam int DEF_REPEAT_PERIOD  = 8;

  function automatic int imax(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/debounce_cell.sv
// One button: debounce counter, level register,
// edge pulses and the hold/auto-repeat state machine.
module debounce_cell
  import bomb_pkg::*;
#(
  parameter int STABLE_SAMPLES = DEF_STABLE_SAMPLES,
  parameter int REPEAT_DELAY   = DEF_REPEAT_DELAY,
  parameter int REPEAT_PERIOD  = DEF_REPEAT_PERIOD
) (
  input  logic clk,
  input  logic rst_n,
  input  logic tick_i,
  input  logic sample_i,
  output logic level_o,
  output logic press_o,
  output logic rel_o,
  output logic rep_o
);

  localparam int CW   = $clog2(STABLE_SAMPLES);
  localparam int RMAX = imax(REPEAT_DELAY, REPEAT_PERIOD);
  localparam int RW   = (RMAX > 2) ? $clog2(RMAX) : 1;

  logic [CW-1:0] cnt_q;
  logic [RW-1:0] rcnt_q;
  btn_state_e    state_q;
  logic          level_q;
  logic          press_q;
  logic          rel_q;
  logic          rep_q;
  logic          differ;
  logic          toggle;

  assign differ = sample_i != level_q;
  assign toggle = tick_i && differ &&
                  (cnt_q == CW'(STABLE_SAMPLES - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q   <= '0;
      rcnt_q  <= '0;
      state_q <= ST_IDLE;
      level_q <= 1'b0;
      press_q <= 1'b0;
      rel_q   <= 1'b0;
      rep_q   <= 1'b0;
    end else begin
      press_q <= 1'b0;
      rel_q   <= 1'b0;
      rep_q   <= 1'b0;
      if (tick_i) begin
        if (!differ || toggle) cnt_q <= '0;
        else                   cnt_q <= cnt_q + 1'b1;
      end
      if (toggle) level_q <= ~level_q;
      // a level change always wins over repeat timing
      unique case (state_q)
        ST_IDLE: begin
          if (toggle) begin
            state_q <= ST_HOLD;
            rcnt_q  <= '0;
            press_q <= 1'b1;
            rep_q   <= 1'b1;
          end
        end
        ST_HOLD: begin
          if (toggle) begin
            state_q <= ST_IDLE;
            rcnt_q  <= '0;
            rel_q   <= 1'b1;
          end else if (tick_i) begin
            if (rcnt_q == RW'(REPEAT_DELAY - 1)) begin
              state_q <= ST_REPEAT;
              rcnt_q  <= '0;
              rep_q   <= 1'b1;
            end else begin
              rcnt_q <= rcnt_q + 1'b1;
            end
          end
        end
        ST_REPEAT: begin
          if (toggle) begin
            state_q <= ST_IDLE;
            rcnt_q  <= '0;
            rel_q   <= 1'b1;
          end else if (tick_i) begin
            if (rcnt_q == RW'(REPEAT_PERIOD - 1)) begin
              rcnt_q <= '0;
              rep_q  <= 1'b1;
            end else begin
              rcnt_q <= rcnt_q + 1'b1;
            end
          end
        end
        default: begin
          state_q <= ST_IDLE;
          rcnt_q  <= '0;
        end
      endcase
    end
  end

  assign level_o = level_q;
  assign press_o = press_q;
  assign rel_o   = rel_q;
  assign rep_o   = rep_q;

endmodule

// File: rtl/key_debounce.sv
// Button front-end: input synchronizers, sample tick
// from a divider bit, and one debounce cell per button.
module key_debounce
  import bomb_pkg::*;
#(
  parameter int NUM_BTN        = DEF_NUM_BTN,
  parameter int STABLE_SAMPLES = DEF_STABLE_SAMPLES,
  parameter int REPEAT_DELAY   = DEF_REPEAT_DELAY,
  parameter int REPEAT_PERIOD  = DEF_REPEAT_PERIOD
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               sample_src,
  input  logic [NUM_BTN-1:0] btn_in,
  output logic [NUM_BTN-1:0] btn_level,
  output logic [NUM_BTN-1:0] btn_press,
  output logic [NUM_BTN-1:0] btn_release,
  output logic [NUM_BTN-1:0] btn_rep
);

  logic [NUM_BTN-1:0] btn_s1_q;
  logic [NUM_BTN-1:0] btn_s2_q;
  logic               src_s1_q;
  logic               src_s2_q;
  logic               src_s3_q;
  logic               tick;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      btn_s1_q <= '0;
      btn_s2_q <= '0;
      src_s1_q <= 1'b0;
      src_s2_q <= 1'b0;
      src_s3_q <= 1'b0;
    end else begin
      btn_s1_q <= btn_in;
      btn_s2_q <= btn_s1_q;
      src_s1_q <= sample_src;
      src_s2_q <= src_s1_q;
      src_s3_q <= src_s2_q;
    end
  end

  // divider bit is data only: its rising edge becomes a 1-clk enable
  assign tick = src_s2_q & ~src_s3_q;

  for (genvar i = 0; i < NUM_BTN; i++) begin : g_cell
    debounce_cell #(
      .STABLE_SAMPLES (STABLE_SAMPLES),
      .REPEAT_DELAY   (REPEAT_DELAY),
      .REPEAT_PERIOD  (REPEAT_PERIOD)
    ) u_cell (
      .clk      (clk),
      .rst_n    (rst_n),
      .tick_i   (tick),
      .sample_i (btn_s2_q[i]),
      .level_o  (btn_level[i]),
      .press_o  (btn_press[i]),
      .rel_o    (btn_release[i]),
      .rep_o    (btn_rep[i])
    );
  end

endmodule

// File: doc/key_debounce.md
KEY_DEBOUNCE -- requirements
Module: key_debounce

Interface
REQ-001 SHALL have parameter NUM_BTN, default 5: number of independent buttons.
REQ-002 SHALL have parameter STABLE_SAMPLES, default 4, legal range 2..15: consecutive agreeing samples needed to change a level.
REQ-003 SHALL have parameter REPEAT_DELAY, default 32: sample ticks of hold before auto-repeat starts.
REQ-004 SHALL have parameter REPEAT_PERIOD, default 8: sample ticks between auto-repeat pulses.
REQ-005 SHALL have port clk, input, 1: single system clock; all state changes on the rising edge.
REQ-006 SHALL have port rst_n, input, 1: reset, asynchronous and active-low.
REQ-007 SHALL have port sample_src, input, 1: slow divider bit from the clock divider's clkdiv bus, e.g. clkdiv[17]; used as data, never as a clock.
REQ-008 SHALL have port btn_in, input, NUM_BTN: raw asynchronous button levels, 1 = pressed.
REQ-009 SHALL have port btn_level, output, NUM_BTN: debounced level per button.
REQ-010 SHALL have port btn_press, output, NUM_BTN: one-clk pulse on each debounced 0->1 transition.
REQ-011 SHALL have port btn_release, output, NUM_BTN: one-clk pulse on each debounced 1->0 transition.
REQ-012 SHALL have port btn_rep, output, NUM_BTN: one-clk pulse on each press and on each auto-repeat event.

Function
REQ-013 SHALL pass btn_in and sample_src through 2-flop synchronizers.
REQ-014 SHALL generate tick, one clk wide, on each synchronized 0->1 edge of sample_src; with no edges, all debounce and repeat state SHALL hold.
REQ-015 SHALL keep a per-button counter; on tick, sample == btn_level clears it, otherwise it increments.
REQ-016 SHALL toggle btn_level and clear the counter on the tick giving STABLE_SAMPLES consecutive differing samples; any agreeing sample in between restarts the count.
REQ-017 Latency from a stable btn_in change to btn_level SHALL be 2 clk plus STABLE_SAMPLES ticks plus the wait to the first tick.
REQ-018 SHALL assert btn_press / btn_release in the same clk cycle that btn_level changes, for exactly one cycle.
REQ-019 SHALL implement a per-button FSM: IDLE (level 0), HOLD (level 1, counting ticks), REPEAT (level 1, periodic).
REQ-020 IDLE->HOLD on press, with a btn_rep pulse; HOLD->REPEAT on the REPEAT_DELAY-th tick, with a btn_rep pulse; REPEAT emits btn_rep every REPEAT_PERIOD ticks.
REQ-021 Release in any state SHALL go to IDLE in that cycle, clear the repeat counter and emit no btn_rep.
REQ-022 Buttons SHALL be fully independent; simultaneous presses produce simultaneous pulses.
REQ-023 Counters SHALL be sized by $clog2 of their maximum and never wrap.

Reset
REQ-024 On rst_n low, all synchronizers, counters, FSMs (IDLE) and all outputs SHALL be 0 immediately.
REQ-025 After reset release, a held button SHALL be treated as a new press: btn_press after STABLE_SAMPLES ticks; reset mid-HOLD/REPEAT SHALL emit no pulse.

Structure
REQ-026 FSM state encoding and default parameter values SHALL live in the shared project package/header bomb_pkg.
REQ-027 SHALL instantiate sub-module debounce_cell once per button in a generate loop; synchronizers and tick generation stay in key_debounce.

Verification (sample_src period 16 clk, STABLE_SAMPLES=4, REPEAT_DELAY=32, REPEAT_PERIOD=8)
REQ-028 btn_in[0] 0->1 held -> btn_level[0]=1 and one btn_press[0] pulse on the 4th tick; other bits stay 0.
REQ-029 btn_in[1] bounce (1 for 2 ticks, 0 for 1 tick, then 1 held) -> exactly one btn_press[1], on the 4th tick after the final rise.
REQ-030 Hold btn_in[2] for 60 ticks -> btn_rep[2] pulses at tick 4 (press), tick 36, then ticks 44, 52, 60; 5 pulses total.
REQ-031 Release during REPEAT -> one btn_release pulse 4 ticks after the fall; no further btn_rep.
REQ-032 Assert rst_n low mid-HOLD with the button held -> outputs 0 asynchronously; after release, one new btn_press after 4 ticks.
REQ-033 sample_src held constant for 1000 clk while btn_in toggles -> no output change.
